edge_threshold: RTL
===================

EDGE_THRESHOLD -- requirements
Module: edge_threshold

Interface
REQ-001 SHALL have parameter SRC_BASE, default 25344, meaning the word address of the first edge-image word (the Sobel output region).
REQ-002 SHALL have parameter NWORDS, default 25344, meaning the number of 32-bit words processed (88 words/row x 288 rows).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates occur on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port addr  output  16  word address for the memory.
REQ-006 SHALL have port dataR  input  32  read data, valid the cycle after a read request.
REQ-007 SHALL have port dataW  output  32  write data.
REQ-008 SHALL have port en  output  1  memory request.
REQ-009 SHALL have port we  output  1  write enable; 1=write, 0=read; meaningful only when en=1.
REQ-010 SHALL have port start  input  1  begin-operation request, level sensitive.
REQ-011 SHALL have port threshold  input  8  binarisation threshold, sampled on the start edge.
REQ-012 SHALL have port finish  output  1  operation complete.
REQ-013 SHALL have port edge_count  output  17  number of pixels set to 8'hFF in the last run.

Function
REQ-014 SHALL binarise the edge image in place: each word at SRC_BASE+i, i=0..NWORDS-1, is read and then rewritten at the same address.
REQ-015 SHALL treat each word as 4 pixels: pixel k occupies bits 8k+7:8k, with k=0 the leftmost pixel.
REQ-016 SHALL output pixel 8'hFF when the unsigned pixel value is strictly greater than the latched threshold, else 8'h00; pixel == threshold SHALL give 8'h00.
REQ-017 SHALL implement states IDLE, RD, WR, DONE.
REQ-018 In IDLE: en=0, we=0, addr=0, dataW=0, finish=0; start=1 latches threshold, clears the word index and edge_count, and moves to RD.
REQ-019 In RD: en=1, we=0, addr=SRC_BASE+index; unconditional move to WR.
REQ-020 In WR: en=1, we=1, addr=SRC_BASE+index, dataW=thresholded dataR (combinational from dataR), edge_count += number of FF bytes (0-4).
REQ-021 WR exit: index==NWORDS-1 -> DONE; otherwise increment the index and move to RD.
REQ-022 In DONE: finish=1, en=0, we=0, addr=0, dataW=0; stay while start=1; start=0 -> IDLE.
REQ-023 SHALL ignore start and threshold changes in RD, WR and DONE.
REQ-024 Throughput SHALL be exactly 2 cycles per word; the first RD cycle immediately follows the start-sampling edge.
REQ-025 finish SHALL rise on the (2*NWORDS+1)th rising edge, counting the start-sampling edge as the first.
REQ-026 Address arithmetic SHALL be 16-bit unsigned; SRC_BASE+NWORDS-1 <= 65535 is a legal-configuration requirement.
REQ-027 edge_count SHALL hold its value after DONE until the next start in IDLE; its maximum is 4*NWORDS = 101376, which fits 17 bits.
REQ-028 addr, en, we and finish SHALL be glitch-free Moore functions of state and index.

Reset
REQ-029 reset=0 SHALL asynchronously force IDLE, index=0, edge_count=0, latched threshold=0, and en=we=finish=0, addr=0, dataW=0.
REQ-030 Reset asserted mid-run SHALL abort the run with no further memory access; words already rewritten stay rewritten.
REQ-031 After reset release, the block SHALL require a new start before any memory access.

Verification
REQ-032 NWORDS=4, SRC_BASE=100, threshold=8'h80, memory words {32'h00FF8081, 32'h7F7F7F7F, 32'hFFFFFFFF, 32'h01020304} -> memory becomes {32'h00FF00FF, 0, 32'hFFFFFFFF, 0}, edge_count=6, finish on edge 9.
REQ-033 Cycle check, same configuration -> the access sequence is rd100, wr100, rd101, wr101, rd102, wr102, rd103, wr103 with no idle cycles and no access outside 100..103.
REQ-034 threshold=8'hFF with all pixels 8'hFF -> every word written 0, edge_count=0; threshold=8'h00 with all pixels 8'h01 -> every word written 32'hFFFFFFFF, edge_count=4*NWORDS.
REQ-035 Threshold changed from 8'h80 to 8'h00 during the run -> results match 8'h80; start held high after finish -> finish stays 1 and no new run until start drops and rises again.
REQ-036 reset pulled low during the WR of word 2 -> outputs zero immediately, edge_count=0, and memory words 2..3 are unchanged.
REQ-037 Default parameters, random image -> 50688 accesses, and edge_count matches the reference model count.

Source files
------------

// File: rtl/edge_threshold_if.sv
// Word-addressed single-port memory bus shared by the thresholding engine and its memory.
// The engine drives the request side; the memory returns dataR one cycle after a read.
interface edge_threshold_if;
  logic [15:0] addr;
  logic [31:0] dataR;
  logic [31:0] dataW;
  logic        en;
  logic        we;

  modport master (output addr, output dataW, output en, output we, input dataR);
  modport slave  (input addr, input dataW, input en, input we, output dataR);
endinterface

// File: rtl/edge_threshold.sv
// In-place binarisation of a packed 8-bit edge image: each 32-bit word is read, its four
// pixels are thresholded to 8'hFF/8'h00, and the word is written back to the same address.
module edge_threshold #(
  parameter int SRC_BASE = 25344,
  parameter int NWORDS   = 25344
) (
  input  logic                 clk,
  input  logic                 reset,
  edge_threshold_if.master     mem,
  input  logic                 start,
  input  logic [7:0]           threshold,
  output logic                 finish,
  output logic [16:0]          edge_count
);

  localparam logic [15:0] BASE16 = 16'(SRC_BASE);
  localparam logic [15:0] LAST   = 16'(NWORDS - 1);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t      state_q, state_d;
  logic [15:0] index_q, index_d;
  logic [7:0]  thr_q, thr_d;
  logic [16:0] count_q, count_d;

  logic [31:0] binW;
  logic [2:0]  hits;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      index_q <= '0;
      thr_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      thr_q   <= thr_d;
      count_q <= count_d;
    end
  end

  // Read data is only meaningful in WR, where it holds the word fetched during RD.
  always_comb begin
    binW = '0;
    hits = '0;
    for (int k = 0; k < 4; k++) begin
      if (mem.dataR[8*k +: 8] > thr_q) begin
        binW[8*k +: 8] = 8'hFF;
        hits           = hits + 3'd1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    index_d = index_q;
    thr_d   = thr_q;
    count_d = count_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          thr_d   = threshold;
          index_d = '0;
          count_d = '0;
          state_d = RD;
        end
      end
      RD: state_d = WR;
      WR: begin
        count_d = count_q + {14'd0, hits};
        if (index_q == LAST) begin
          state_d = DONE;
        end else begin
          index_d = index_q + 16'd1;
          state_d = RD;
        end
      end
      DONE: begin
        if (!start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Bus outputs decode only registered state, so they never follow dataR except dataW in WR.
  always_comb begin
    mem.en    = (state_q == RD) || (state_q == WR);
    mem.we    = (state_q == WR);
    mem.addr  = mem.en ? (BASE16 + index_q) : 16'd0;
    mem.dataW = (state_q == WR) ? binW : 32'd0;
    finish    = (state_q == DONE);
  end

  assign edge_count = count_q;

endmodule
